// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder/subtractor: processes CHUNK bits per clock, LSB slice first,
// and publishes sum/cout/ovf with a one-cycle done pulse once the last slice lands.
module seq_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy,
  output logic             done
);
  localparam int N  = WIDTH / CHUNK;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, sum_q, sum_d;
  logic             cout_q, cout_d, ovf_q, ovf_d, done_q, done_d;
  logic [CHUNK:0]   slice;
  logic             last;

  // b_q holds the already-inverted operand for subtract, so RUN is a plain add.
  always_comb begin
    slice = {1'b0, a_q[idx_q*CHUNK +: CHUNK]} + {1'b0, b_q[idx_q*CHUNK +: CHUNK]}
          + (CHUNK+1)'(carry_q);
    last  = (idx_q == IW'(N-1));
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        res_d[idx_q*CHUNK +: CHUNK] = slice[CHUNK-1:0];
        carry_d = slice[CHUNK];
        idx_d   = idx_q + 1'b1;
        if (last) begin
          // Carry into the MSB is recovered from the MSB sum bit and its operands.
          sum_d   = res_d;
          cout_d  = slice[CHUNK];
          ovf_d   = slice[CHUNK] ^ (a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ slice[CHUNK-1]);
          done_d  = 1'b1;
          idx_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
  assign busy = (state_q == RUN);
  assign done = done_q;
endmodule

// File: tb/tb_seq_chunk_adder.sv
// Directed bench for seq_chunk_adder: four instances cover 16/4, 8/2, 16/16 and 16/1.
module tb_seq_chunk_adder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]       st, sb, rn, co, ov, bz, dn;
  logic [3:0][15:0] aa, bb, sm;
  int errors = 0;
  int checks = 0;

  seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) u0 (
    .clk(clk), .rst_n(rn[0]), .start(st[0]), .sub(sb[0]), .a(aa[0]), .b(bb[0]),
    .sum(sm[0]), .cout(co[0]), .ovf(ov[0]), .busy(bz[0]), .done(dn[0]));
  seq_chunk_adder #(.WIDTH(8), .CHUNK(2)) u1 (
    .clk(clk), .rst_n(rn[1]), .start(st[1]), .sub(sb[1]), .a(aa[1][7:0]), .b(bb[1][7:0]),
    .sum(sm[1][7:0]), .cout(co[1]), .ovf(ov[1]), .busy(bz[1]), .done(dn[1]));
  assign sm[1][15:8] = '0;
  seq_chunk_adder #(.WIDTH(16), .CHUNK(16)) u2 (
    .clk(clk), .rst_n(rn[2]), .start(st[2]), .sub(sb[2]), .a(aa[2]), .b(bb[2]),
    .sum(sm[2]), .cout(co[2]), .ovf(ov[2]), .busy(bz[2]), .done(dn[2]));
  seq_chunk_adder #(.WIDTH(16), .CHUNK(1)) u3 (
    .clk(clk), .rst_n(rn[3]), .start(st[3]), .sub(sb[3]), .a(aa[3]), .b(bb[3]),
    .sum(sm[3]), .cout(co[3]), .ovf(ov[3]), .busy(bz[3]), .done(dn[3]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Golden 16-bit result: {ovf, cout, sum}
  function automatic logic [17:0] gold(input logic s, input logic [15:0] x, input logic [15:0] y);
    logic [15:0] yy;
    logic [16:0] r;
    logic        o;
    yy = s ? ~y : y;
    r  = {1'b0, x} + {1'b0, yy} + 17'(s);
    o  = (x[15] == yy[15]) && (r[15] != x[15]);
    return {o, r};
  endfunction

  // Called #1 after a rising edge; drives start now so the next edge accepts.
  task automatic run_op(input int s, input int n, input logic sub, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] es, input logic ec,
                        input logic eo, input string tag);
    int bcnt, lat;
    bit got;
    st[s] = 1'b1; aa[s] = a; bb[s] = b; sb[s] = sub;
    @(posedge clk); #1;
    st[s] = 1'b0;
    bcnt = 0; lat = 0; got = 0;
    for (int i = 1; i <= 40; i++) begin
      if (dn[s]) begin got = 1; lat = i; break; end
      if (bz[s]) bcnt++;
      @(posedge clk); #1;
    end
    chk({tag, ".done_seen"}, 32'(got), 32'd1);
    chk({tag, ".latency"}, 32'(lat), 32'(n + 1));
    chk({tag, ".busy_cycles"}, 32'(bcnt), 32'(n));
    chk({tag, ".busy_at_done"}, 32'(bz[s]), 32'd0);
    chk({tag, ".sum"}, 32'(sm[s]), 32'(es));
    chk({tag, ".cout"}, 32'(co[s]), 32'(ec));
    chk({tag, ".ovf"}, 32'(ov[s]), 32'(eo));
    @(posedge clk); #1;
    chk({tag, ".done_pulse"}, 32'(dn[s]), 32'd0);
    chk({tag, ".sum_hold"}, 32'(sm[s]), 32'(es));
  endtask

  // Start held high: a new result every n+1 cycles, new operands loaded in each done cycle.
  task automatic run_cont(input int s, input int n, input string tag);
    logic [15:0] va[4] = '{16'h1234, 16'h0003, 16'hFFFF, 16'h8000};
    logic [15:0] vb[4] = '{16'h4321, 16'h0005, 16'h0001, 16'h0001};
    logic        vs[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [17:0] g;
    int cnt, prev, k;
    k = 0; cnt = 0; prev = 0;
    st[s] = 1'b1; aa[s] = va[0]; bb[s] = vb[0]; sb[s] = vs[0];
    for (int i = 0; i < 200 && k < 4; i++) begin
      @(posedge clk); #1;
      cnt++;
      if (dn[s]) begin
        g = gold(vs[k], va[k], vb[k]);
        chk($sformatf("%s.sum%0d", tag, k), 32'(sm[s]), 32'(g[15:0]));
        chk($sformatf("%s.cout%0d", tag, k), 32'(co[s]), 32'(g[16]));
        chk($sformatf("%s.ovf%0d", tag, k), 32'(ov[s]), 32'(g[17]));
        if (k > 0) chk($sformatf("%s.period%0d", tag, k), 32'(cnt - prev), 32'(n + 1));
        prev = cnt;
        k++;
        if (k < 4) begin aa[s] = va[k]; bb[s] = vb[k]; sb[s] = vs[k]; end
      end
    end
    st[s] = 1'b0;
    chk({tag, ".results"}, 32'(k), 32'd4);
  endtask

  initial begin
    int ndone;
    logic [15:0] sum_at;
    st = '0; sb = '0; rn = '0; aa = '0; bb = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.sum", 32'(sm[0]), 32'd0);
    chk("rst.cout", 32'(co[0]), 32'd0);
    chk("rst.ovf", 32'(ov[0]), 32'd0);
    chk("rst.busy", 32'(bz[0]), 32'd0);
    chk("rst.done", 32'(dn[0]), 32'd0);
    chk("rst.busy8", 32'(bz[1]), 32'd0);

    // Release reset with start already high: first edge out of reset accepts.
    rn = '1;
    run_op(0, 4, 1'b0, 16'h0012, 16'h0095, 16'h00A7, 1'b0, 1'b0, "add_a7");
    run_op(0, 4, 1'b1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0, "sub_borrow");
    run_op(0, 4, 1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1, "sub_ovf");
    run_op(0, 4, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, "add_ovf");
    run_op(1, 4, 1'b0, 16'h0001, 16'h00FF, 16'h0000, 1'b1, 1'b0, "w8_wrap");
    run_op(1, 4, 1'b0, 16'h00D2, 16'h0095, 16'h0067, 1'b1, 1'b1, "w8_ovf");

    // Start pulsed while busy and operands changed mid-run must be ignored.
    st[0] = 1'b1; aa[0] = 16'h1111; bb[0] = 16'h2222; sb[0] = 1'b0;
    @(posedge clk); #1;
    aa[0] = 16'hFFFF; bb[0] = 16'hFFFF;
    @(posedge clk); #1;
    st[0] = 1'b0; aa[0] = 16'h1234; bb[0] = 16'h0F0F; sb[0] = 1'b1;
    ndone = 0; sum_at = '0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (dn[0]) begin ndone++; sum_at = sm[0]; end
    end
    chk("ignore.dones", 32'(ndone), 32'd1);
    chk("ignore.sum", 32'(sum_at), 32'h3333);

    // Reset on the second RUN edge aborts the operation.
    st[0] = 1'b1; aa[0] = 16'h00FF; bb[0] = 16'h0001; sb[0] = 1'b0;
    @(posedge clk); #1;
    st[0] = 1'b0;
    @(posedge clk); #1;
    rn[0] = 1'b0;
    @(posedge clk); #1;
    chk("abort.busy", 32'(bz[0]), 32'd0);
    chk("abort.done", 32'(dn[0]), 32'd0);
    chk("abort.sum", 32'(sm[0]), 32'd0);
    rn[0] = 1'b1;
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (dn[0]) ndone++;
    end
    chk("abort.no_done", 32'(ndone), 32'd0);
    chk("abort.sum_kept", 32'(sm[0]), 32'd0);
    run_op(0, 4, 1'b0, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0, "after_abort");

    run_cont(2, 1, "cont_n1");
    run_cont(3, 16, "cont_n16");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/seq_chunk_adder.md
SEQ_CHUNK_ADDER -- requirements
Module: seq_chunk_adder

Interface
REQ-001 Parameter: WIDTH, 16, operand and result width in bits.
REQ-002 Parameter: CHUNK, 4, bits added per clock cycle; WIDTH SHALL be an integer multiple of CHUNK, and CHUNK SHALL be between 1 and WIDTH.
REQ-003 Port: clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 Port: rst_n  input  1  reset, synchronous and active-low.
REQ-005 Port: start  input  1  request to begin an operation.
REQ-006 Port: sub  input  1  mode select: 0 = a+b, 1 = a-b; sampled with the operands.
REQ-007 Port: a  input  WIDTH  operand A.
REQ-008 Port: b  input  WIDTH  operand B.
REQ-009 Port: sum  output  WIDTH  registered result of the last completed operation.
REQ-010 Port: cout  output  1  carry out of the MSB of the last result; for subtract, 1 = no borrow.
REQ-011 Port: ovf  output  1  two's-complement signed overflow of the last result.
REQ-012 Port: busy  output  1  high while an operation is in progress.
REQ-013 Port: done  output  1  one-cycle pulse when sum/cout/ovf are updated.

Function
REQ-014 The block SHALL implement FSM states IDLE and RUN; N = WIDTH/CHUNK.
REQ-015 Accept: the block SHALL accept an operation on a rising edge where start=1 and busy=0; it SHALL then latch a, b and sub, clear the chunk index, go to RUN and set busy=1.
REQ-016 Subtract: the block SHALL use ~b as the B operand and a carry-in of 1; for add, it SHALL use b and a carry-in of 0.
REQ-017 RUN: on each edge, the block SHALL add one CHUNK slice (LSB slice first) plus the registered carry, store the slice result, register the carry out, and increment the index.
REQ-018 On the N-th RUN edge, the block SHALL write the full result to sum, the final carry to cout and ovf = carry into MSB XOR carry out of MSB; it SHALL also set done=1 for exactly one cycle, set busy=0 and return to IDLE.
REQ-019 Latency: for start accepted at edge E, done SHALL be high in the cycle following edge E+N; CHUNK=WIDTH SHALL give N=1.
REQ-020 sum, cout and ovf SHALL hold their values between done pulses; intermediate slice results SHALL NOT be visible on sum.
REQ-021 The block SHALL ignore start while busy=1: no restart and no operand change.
REQ-022 The block SHALL ignore changes on a, b and sub after acceptance.
REQ-023 Back-to-back: start=1 in the done cycle (busy=0) SHALL be accepted, so a new result follows every N+1 cycles.
REQ-024 Carry/overflow SHALL wrap modulo 2^WIDTH; sum never extends.

Reset
REQ-025 With rst_n=0 at a rising edge, the block SHALL set sum=0, cout=0, ovf=0, busy=0, done=0, FSM=IDLE and the chunk index and internal carry to 0.
REQ-026 Reset SHALL take priority over start and over RUN progress: an in-flight operation SHALL be aborted with no done pulse and sum left at 0.
REQ-027 The first accept SHALL be possible on the first edge with rst_n=1 and start=1.

Verification
REQ-028 Default params, sub=0, a=16'h0012, b=16'h0095 -> after 4 RUN edges: done=1 once, sum=16'h00A7, cout=0, ovf=0; busy high for exactly 4 cycles.
REQ-029 WIDTH=8, CHUNK=2, sub=0, a=8'h01, b=8'hFF -> done after 4 RUN edges, sum=8'h00, cout=1, ovf=0; 8'hD2+8'h95 -> sum=8'h67, cout=1, ovf=1.
REQ-030 Default params, sub=1, a=16'h0005, b=16'h0007 -> sum=16'hFFFE, cout=0, ovf=0; a=16'h8000, b=16'h0001 -> sum=16'h7FFF, cout=1, ovf=1; add 16'h7FFF+16'h0001 -> sum=16'h8000, ovf=1, cout=0.
REQ-031 Start 16'h1111+16'h2222, pulse start with 16'hFFFF+16'hFFFF while busy, then change a and b mid-run -> sum=16'h3333 and exactly one done pulse.
REQ-032 Start an operation, drive rst_n=0 on the second RUN edge -> busy=0, done never pulses, sum=0; a new start after release gives the correct result.
REQ-033 Hold start=1 continuously with CHUNK=WIDTH -> done asserts every 2 cycles; with CHUNK=1, WIDTH=16 -> done asserts every 17 cycles, and each result matches the golden a±b.
